// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: SoC-facing read and error-flag bus of the UART receiver
interface uart_rx_fifo_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_pop;
    logic       frame_err;
    logic       overrun;
    logic       clear_err;
    modport master (input rd_data, rd_valid, frame_err, overrun, output rd_pop, clear_err);
    modport slave  (output rd_data, rd_valid, frame_err, overrun, input rd_pop, clear_err);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling 8N1 UART receiver feeding a FWFT FIFO with cts_n flow control
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 416,
    parameter int FIFO_AW      = 4,
    parameter int CTS_MARGIN   = 4
) (
    input  logic clk_core,
    input  logic reset_n,
    input  logic rx,
    output logic cts_n,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int TW    = $clog2(CLKS_PER_BIT);
    localparam int CW    = FIFO_AW + 1;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t state;
    logic [TW-1:0] timer;
    logic [2:0] bitcnt;
    logic [7:0] shreg;
    logic rx_m, rx_s, started;
    logic [7:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_next;
    logic bit_end, stop_hit, pop, full, push;
    assign bit_end    = timer == TW'(CLKS_PER_BIT - 1);
    assign stop_hit   = state == STOP && bit_end;
    assign pop        = bus.rd_pop && count != '0;
    assign full       = count == CW'(DEPTH);
    // a pop in the stop-sample cycle frees the slot the new byte needs
    assign push       = stop_hit && rx_s && (!full || pop);
    assign count_next = count + CW'(push) - CW'(pop);
    assign bus.rd_valid = count != '0;
    assign bus.rd_data  = bus.rd_valid ? mem[rptr] : '0;
    always_ff @(posedge clk_core or negedge reset_n)
        if (!reset_n) begin
            state  <= IDLE;
            timer  <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else begin
            case (state)
                IDLE:  if (!rx_s) begin
                           state <= START;
                           timer <= '0;
                       end
                START: if (timer == TW'(HALF - 1)) begin
                           state  <= rx_s ? IDLE : DATA;
                           timer  <= '0;
                           bitcnt <= '0;
                       end else timer <= timer + 1'b1;
                DATA:  if (bit_end) begin
                           shreg  <= {rx_s, shreg[7:1]};
                           bitcnt <= bitcnt + 1'b1;
                           timer  <= '0;
                           state  <= bitcnt == 3'd7 ? STOP : DATA;
                       end else timer <= timer + 1'b1;
                STOP:  if (bit_end) begin
                           state <= rx_s ? IDLE : BREAK;
                           timer <= '0;
                       end else timer <= timer + 1'b1;
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    always_ff @(posedge clk_core)
        if (push) mem[wptr] <= shreg;
    always_ff @(posedge clk_core or negedge reset_n)
        if (!reset_n) begin
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            started       <= 1'b0;
            cts_n         <= 1'b1;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            rx_m          <= rx;
            rx_s          <= rx_m;
            wptr          <= wptr + FIFO_AW'(push);
            rptr          <= rptr + FIFO_AW'(pop);
            count         <= count_next;
            started       <= 1'b1;
            cts_n         <= started ? (CW'(DEPTH) - count_next) <= CW'(CTS_MARGIN) : 1'b1;
            bus.frame_err <= (stop_hit && !rx_s) ? 1'b1 : bus.clear_err ? 1'b0 : bus.frame_err;
            bus.overrun   <= (stop_hit && rx_s && full && !pop) ? 1'b1 : bus.clear_err ? 1'b0 : bus.overrun;
        end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random 8N1 traffic against a queue-based receiver model
module tb_uart_rx_fifo;
    logic clk_core = 1'b0;
    logic reset_n = 1'b0;
    logic rx = 1'b1;
    logic cts_n;
    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic frm_exp = 1'b0;
    logic ovr_exp = 1'b0;
    uart_rx_fifo_if bus ();
    uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_AW(4), .CTS_MARGIN(4)) dut (
        .clk_core(clk_core),
        .reset_n (reset_n),
        .rx      (rx),
        .cts_n   (cts_n),
        .bus     (bus)
    );
    always #5 clk_core = ~clk_core;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk_core);
    endtask
    // one frame: start bit, 8 data bits LSB first, stop level held stop_bits bit times
    task automatic send(input logic [7:0] b, input logic stop_v, input int stop_bits, input bit pop_stop);
        logic [8:0] frame;
        frame = {b, 1'b0};
        for (int i = 0; i < 16 * (9 + stop_bits); i++) begin
            @(negedge clk_core);
            rx = (i / 16 >= 9) ? stop_v : frame[i / 16];
            bus.rd_pop = pop_stop && i == 154;
            @(posedge clk_core);
        end
        @(negedge clk_core);
        rx = 1'b1;
        bus.rd_pop = 1'b0;
    endtask
    task automatic model_rx(input logic [7:0] b);
        if (q.size() < 16) q.push_back(b);
        else ovr_exp = 1'b1;
    endtask
    task automatic check_state(input string tag);
        chk({tag, ".rd_valid"}, bus.rd_valid, q.size() != 0);
        if (q.size() != 0) chk({tag, ".rd_data"}, bus.rd_data, q[0]);
        chk({tag, ".frame_err"}, bus.frame_err, frm_exp);
        chk({tag, ".overrun"}, bus.overrun, ovr_exp);
        chk({tag, ".cts_n"}, cts_n, (16 - q.size()) <= 4);
    endtask
    task automatic pop_one(input string tag);
        chk({tag, ".pop_valid"}, bus.rd_valid, 1);
        chk({tag, ".pop_data"}, bus.rd_data, q[0]);
        bus.rd_pop = 1'b1;
        @(negedge clk_core);
        bus.rd_pop = 1'b0;
        void'(q.pop_front());
    endtask
    task automatic clear_flags();
        bus.clear_err = 1'b1;
        @(negedge clk_core);
        bus.clear_err = 1'b0;
        frm_exp = 1'b0;
        ovr_exp = 1'b0;
        @(negedge clk_core);
    endtask
    task automatic check_reset_values(input string tag);
        chk({tag, ".rd_valid"}, bus.rd_valid, 0);
        chk({tag, ".rd_data"}, bus.rd_data, 0);
        chk({tag, ".cts_n"}, cts_n, 1);
        chk({tag, ".frame_err"}, bus.frame_err, 0);
        chk({tag, ".overrun"}, bus.overrun, 0);
    endtask
    initial begin
        logic [7:0] b;
        bus.rd_pop = 1'b0;
        bus.clear_err = 1'b0;
        idle(3);
        check_reset_values("reset");
        reset_n = 1'b1;
        idle(4);
        check_state("post_reset");
        send(8'hA5, 1'b1, 1, 1'b0);
        model_rx(8'hA5);
        idle(2);
        check_state("a5");
        pop_one("a5");
        check_state("a5_popped");
        repeat (4) begin
            b = 8'($urandom);
            send(b, 1'b1, 1, 1'b0);
            model_rx(b);
            idle(1);
            check_state("rand");
        end
        while (q.size() != 0) pop_one("rand_drain");
        check_state("rand_empty");
        rx = 1'b0;
        idle(6);
        rx = 1'b1;
        idle(40);
        check_state("glitch");
        send(8'h3C, 1'b0, 3, 1'b0);
        frm_exp = 1'b1;
        idle(4);
        check_state("framing");
        send(8'h81, 1'b1, 1, 1'b0);
        model_rx(8'h81);
        idle(2);
        check_state("after_framing");
        pop_one("after_framing");
        clear_flags();
        check_state("clear_frame");
        for (int i = 0; i <= 16; i++) begin
            send(8'(i), 1'b1, 1, 1'b0);
            model_rx(8'(i));
            idle(2);
            check_state("fill");
        end
        clear_flags();
        check_state("clear_overrun");
        b = 8'($urandom);
        chk("full_head", bus.rd_data, q[0]);
        send(b, 1'b1, 1, 1'b1);
        void'(q.pop_front());
        model_rx(b);
        idle(2);
        check_state("full_pop_push");
        chk("full_count", q.size(), 16);
        while (q.size() != 0) pop_one("full_drain");
        check_state("full_empty");
        send(8'h5A, 1'b1, 1, 1'b0);
        model_rx(8'h5A);
        send(8'h00, 1'b0, 2, 1'b0);
        frm_exp = 1'b1;
        idle(3);
        check_state("pre_reset");
        for (int i = 0; i < 88; i++) begin
            @(negedge clk_core);
            rx = i >= 16;
        end
        @(negedge clk_core);
        reset_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        idle(5);
        check_reset_values("held_reset");
        q.delete();
        frm_exp = 1'b0;
        ovr_exp = 1'b0;
        reset_n = 1'b1;
        idle(4);
        check_state("post_abort");
        send(8'h12, 1'b1, 1, 1'b0);
        model_rx(8'h12);
        idle(2);
        check_state("after_abort");
        pop_one("after_abort");
        idle(40);
        check_state("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Hardware UART receiver placed between the board RX pin and the SoC input port. It replaces bit-banged reception.
- Oversamples RX and deframes 8N1 characters into a FWFT FIFO that the SoC pops.
- Generates cts_n flow control from FIFO occupancy.
- Sticky framing and overrun error flags are visible to firmware.

Parameters:
- CLKS_PER_BIT, 416, clk_core cycles per bit (47.92 MHz / 115200). Must be ≥ 8.
- FIFO_AW, 4, log2 of FIFO depth (depth 16).
- CTS_MARGIN, 4, free-slot count at or below which cts_n deasserts the sender.

Ports:
- clk_core  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- rx  in  1  raw RX pin, asynchronous to clk_core, idle high
- cts_n  out  1  flow control to host; 0 = send permitted
- rd_data  out  8  head-of-FIFO byte; valid only while rd_valid=1
- rd_valid  out  1  FIFO non-empty
- rd_pop  in  1  one-cycle strobe; removes head byte
- frame_err  out  1  sticky: a stop bit was sampled low
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- clear_err  in  1  one-cycle strobe; clears frame_err and overrun

Behaviour:
- Decided: reset is reset_n, asynchronous, active-low; clock is clk_core.
- Reset values: rd_valid=0, rd_data=0, cts_n=1, frame_err=0, overrun=0, FIFO empty, FSM=IDLE, synchroniser flops=1.
- cts_n also holds 1 for one cycle after reset release, then follows the occupancy rule.
- Synchroniser: 2 flops, rx→rx_s. All logic uses rx_s only. Input latency is 2 cycles.
- Bit timer: counts 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2 (floor).
- FSM states IDLE, START, DATA, STOP, BREAK:
  - IDLE: when rx_s=0 → START, timer=0.
  - START: at timer==HALF-1, sample rx_s.
    - Sample 1 (glitch) → IDLE, nothing recorded.
    - Sample 0 → DATA, timer=0, bitcnt=0.
  - DATA: at timer==CLKS_PER_BIT-1, shift rx_s into shreg LSB-first and increment bitcnt. After the 8th sample → STOP, timer=0.
  - STOP: at timer==CLKS_PER_BIT-1, sample rx_s.
    - 1, FIFO accepts → push shreg → IDLE.
    - 1, FIFO full and no simultaneous pop → set overrun, discard byte → IDLE.
    - 0 → set frame_err, no push → BREAK.
  - BREAK: wait for rx_s=1 → IDLE. A held-low line produces exactly one frame_err and no further characters.
- Push occurs in the same cycle as the stop sample. The byte appears on rd_data/rd_valid the next cycle.
- FIFO: FWFT, 2^FIFO_AW entries, pointers wrap modulo depth, count is FIFO_AW+1 bits.
  - rd_pop while rd_valid=0 is ignored; no pointer change.
  - Push and pop in the same cycle while full: both succeed; count unchanged; no overrun.
  - Push and pop in the same cycle while empty: the push succeeds and the pop is ignored.
- cts_n is registered: 1 when (depth − count_next) ≤ CTS_MARGIN, else 0.
- Error flags:
  - Set has priority over clear_err in the same cycle.
  - Flags never affect reception or the FIFO.
- Reset mid-frame: asserting reset_n low aborts the frame immediately. All state returns to reset values and the partial byte is lost.

Test Plan:
- CLKS_PER_BIT=16; send 8N1 0xA5 → rd_valid rises within 1 cycle of stop-bit centre; rd_data=0xA5; frame_err=0. rd_pop → rd_valid=0.
- RX low pulse of 6 cycles (< HALF=8) while idle → no push, no error flags, FSM back in IDLE.
- Send 0x3C with stop bit held low for 3 bit times → frame_err=1, FIFO empty, no spurious byte. Then a valid 0x81 is received correctly. clear_err → frame_err=0.
- Send 17 bytes 0x00..0x10 with no pops, depth 16 → cts_n=1 once 12 bytes are held; overrun=1 after the 17th; 16 pops return 0x00..0x0F in order.
- FIFO full: pop asserted in the same cycle as a stop-bit push → count stays 16, overrun stays 0, new byte is last out.
- Assert reset_n low during DATA bit 4 of 0xFF, release, send 0x12 → only 0x12 is received; all outputs at reset values during reset.
